// File: rtl/paddle_cmd_tx.sv
// Paddle keyboard command transmitter: sends 8N1 frames for paddle level changes and start requests.
// Optional build macro PADDLE_CMD_TX_SYNC_EN adds a 2-flop synchronizer on all five inputs.
module paddle_cmd_tx #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BIT_RATE     = 115_200,
  parameter int CLKS_PER_BIT = CLK_HZ / BIT_RATE
) (
  input  logic clk,
  input  logic rst,
  input  logic p1_up,
  input  logic p1_down,
  input  logic p2_up,
  input  logic p2_down,
  input  logic start_req,
  output logic uart_tx,
  output logic busy,
  output logic tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic [4:0] in_raw;
  logic [4:0] in_s;
  assign in_raw = {start_req, p2_down, p2_up, p1_down, p1_up};

`ifdef PADDLE_CMD_TX_SYNC_EN
  logic [4:0] sync1_q, sync2_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_raw;
      sync2_q <= sync1_q;
    end
  end
  assign in_s = sync2_q;
`else
  assign in_s = in_raw;
`endif

  state_e              state_q, state_d;
  logic [3:0]          cur_q, cur_d;
  logic [3:0]          sent_q, sent_d;
  logic                start_pend_q, start_pend_d;
  logic [7:0]          shift_q, shift_d;
  logic [2:0]          bit_q, bit_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic                tx_q, tx_d;

  logic [3:0] pending;
  logic [1:0] sel;
  logic [7:0] upper;
  logic       baud_end;

  assign pending  = cur_q ^ sent_q;
  assign baud_end = (baud_q == BAUD_LAST);

  // Lowest index wins, giving p1_up > p1_down > p2_up > p2_down.
  always_comb begin
    sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending[i]) sel = 2'(i);
    end
    case (sel)
      2'd0:    upper = 8'h57;
      2'd1:    upper = 8'h53;
      2'd2:    upper = 8'h49;
      default: upper = 8'h4B;
    endcase
  end

  // NOTE: every always_comb output is defaulted first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    cur_d        = in_s[3:0];
    sent_d       = sent_q;
    start_pend_d = start_pend_q | in_s[4];
    shift_d      = shift_q;
    bit_d        = bit_q;
    baud_d       = baud_q;
    tx_d         = tx_q;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (start_pend_q || (|pending)) begin
          state_d = S_START;
          tx_d    = 1'b0;
          baud_d  = '0;
          bit_d   = '0;
          if (start_pend_q) begin
            shift_d      = 8'hAA;
            // A request arriving on the load edge survives, so it yields another 0xAA.
            start_pend_d = in_s[4];
          end else begin
            shift_d     = cur_q[sel] ? upper : (upper | 8'h20);
            sent_d[sel] = cur_q[sel];
          end
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; tx_q resets high so the line idles on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cur_q        <= '0;
      sent_q       <= '0;
      start_pend_q <= 1'b0;
      shift_q      <= '0;
      bit_q        <= '0;
      baud_q       <= '0;
      tx_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      sent_q       <= sent_d;
      start_pend_q <= start_pend_d;
      shift_q      <= shift_d;
      bit_q        <= bit_d;
      baud_q       <= baud_d;
      tx_q         <= tx_d;
    end
  end

  assign uart_tx = tx_q;
  assign busy    = (state_q != S_IDLE);
  assign tx_done = (state_q == S_STOP) && baud_end;

endmodule

// File: tb/tb_paddle_cmd_tx.sv
// Self-checking bench for paddle_cmd_tx: a line-level UART receiver decodes frames and
// compares them with a change-list model of the command protocol.
module tb_paddle_cmd_tx;

  localparam int CPB       = 10;
  localparam int FRAME     = 10 * CPB;
  localparam int PERIOD    = 10;
  localparam int EXTRA_LAT = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0, start_req = 1'b0;
  logic uart_tx, busy, tx_done;

  paddle_cmd_tx #(.CLK_HZ(1000), .BIT_RATE(100)) dut (
    .clk(clk), .rst(rst),
    .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
    .start_req(start_req),
    .uart_tx(uart_tx), .busy(busy), .tx_done(tx_done)
  );

  always #(PERIOD/2) clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Receiver: samples the line on falling clock edges, mid-bit.
  logic [7:0] byte_q[$];
  time        start_q[$];
  time        done_q[$];
  int         bad_frames = 0;
  int         mon_phase = -1;
  logic [7:0] mon_sh = '0;
  logic       mon_bad = 1'b0;

  always @(negedge clk) begin
    if (tx_done) done_q.push_back($time);
    if (!rst) begin
      mon_phase = -1;
    end else if (mon_phase < 0) begin
      if (!uart_tx) begin
        mon_phase = 0;
        mon_bad   = 1'b0;
        start_q.push_back($time);
      end
    end else begin
      mon_phase++;
      if (mon_phase == CPB/2 && uart_tx) mon_bad = 1'b1;
      if (mon_phase >= CPB + CPB/2 && mon_phase <= 8*CPB + CPB/2 && (mon_phase % CPB) == CPB/2)
        mon_sh = {uart_tx, mon_sh[7:1]};
      if (mon_phase == 9*CPB + CPB/2) begin
        if (!uart_tx) mon_bad = 1'b1;
        if (mon_bad) bad_frames++;
        byte_q.push_back(mon_sh);
      end
      if (mon_phase == FRAME - 1) mon_phase = -1;
    end
  end

  task automatic clear_mon();
    byte_q.delete();
    start_q.delete();
    done_q.delete();
    bad_frames = 0;
  endtask

  // Protocol model: one byte per control whose level differs from what was last sent.
  logic [7:0] up_code[4] = '{"W", "S", "I", "K"};
  logic [3:0] model_sent = 4'b0000;
  logic [7:0] exp_q[$];

  task automatic build_exp(input logic [3:0] lv, input logic st);
    exp_q.delete();
    if (st) exp_q.push_back(8'hAA);
    for (int i = 0; i < 4; i++)
      if (lv[i] != model_sent[i]) exp_q.push_back(lv[i] ? up_code[i] : up_code[i] + 8'h20);
  endtask

  task automatic set_levels(input logic [3:0] lv);
    {p2_down, p2_up, p1_down, p1_up} = lv;
  endtask

  task automatic compare_frames(input string tag);
    check({tag, " count"}, byte_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < byte_q.size()) check($sformatf("%s byte%0d", tag, i), byte_q[i], exp_q[i]);
    check({tag, " tx_done"}, done_q.size(), exp_q.size());
    check({tag, " framing"}, bad_frames, 0);
    check({tag, " idle"}, {busy, uart_tx}, 2'b01);
    clear_mon();
  endtask

  task automatic run_step(input logic [3:0] lv, input logic st, input string tag);
    @(negedge clk); #1;
    clear_mon();
    set_levels(lv);
    start_req = st;
    @(negedge clk); #1;
    start_req = 1'b0;
    repeat (exp_q.size() * (FRAME + 1) + 30) @(negedge clk);
    #1;
    compare_frames(tag);
    model_sent = lv;
  endtask

  task automatic wait_start(input int n, input int budget, input string tag);
    int k = 0;
    while (start_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    #1;
    check({tag, " start seen"}, start_q.size() >= n, 1);
  endtask

  typedef struct packed {
    logic [3:0]      lv;
    logic            st;
    logic [2:0]      n;
    logic [4:0][7:0] b;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] lv, input logic st, input int n,
                              input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4);
    vec_t v;
    v.lv = lv; v.st = st; v.n = 3'(n);
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4;
    return v;
  endfunction

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    time  t0;
    int   k;

    vecs[0] = mk(4'b0001, 1'b0, 1, 8'h57, 0, 0, 0, 0);
    vecs[1] = mk(4'b0000, 1'b0, 1, 8'h77, 0, 0, 0, 0);
    vecs[2] = mk(4'b0010, 1'b0, 1, 8'h53, 0, 0, 0, 0);
    vecs[3] = mk(4'b0100, 1'b1, 3, 8'hAA, 8'h73, 8'h49, 0, 0);
    vecs[4] = mk(4'b1000, 1'b0, 2, 8'h69, 8'h4B, 0, 0, 0);
    vecs[5] = mk(4'b1111, 1'b0, 3, 8'h57, 8'h53, 8'h49, 0, 0);
    vecs[6] = mk(4'b0000, 1'b1, 5, 8'hAA, 8'h77, 8'h73, 8'h69, 8'h6B);
    vecs[7] = mk(4'b0000, 1'b0, 0, 0, 0, 0, 0, 0);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset uart_tx", uart_tx, 1);
    check("reset busy", busy, 0);
    check("reset tx_done", tx_done, 0);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post-reset idle line", {busy, uart_tx}, 2'b01);

    // Single p1_up frame: latency, content, frame length
    @(negedge clk); t0 = $time; #1;
    clear_mon();
    p1_up = 1'b1;
    wait_start(1, 30, "t1");
    if (start_q.size() > 0) check("t1 latency", start_q[0] - t0, (2 + EXTRA_LAT) * PERIOD);
    repeat (FRAME + 20) @(negedge clk); #1;
    exp_q = '{8'h57};
    if (done_q.size() > 0 && start_q.size() > 0)
      check("t1 frame length", done_q[0] - start_q[0], (FRAME - 1) * PERIOD);
    compare_frames("t1");
    model_sent = 4'b0001;
    build_exp(4'b0000, 1'b0);
    run_step(4'b0000, 1'b0, "t1 release");

    // Two simultaneous controls: back-to-back frames one idle cycle apart
    @(negedge clk); #1;
    clear_mon();
    set_levels(4'b1001);
    repeat (2 * (FRAME + 1) + 30) @(negedge clk); #1;
    if (start_q.size() >= 2) check("t2 start spacing", start_q[1] - start_q[0], (FRAME + 1) * PERIOD);
    else check("t2 two starts", start_q.size(), 2);
    exp_q = '{8'h57, 8'h4B};
    compare_frames("t2");
    model_sent = 4'b1001;
    build_exp(4'b0000, 1'b0);
    run_step(4'b0000, 1'b0, "t2 release");

    // Start request beats a paddle change
    build_exp(4'b0010, 1'b1);
    run_step(4'b0010, 1'b1, "t3 start+p1_down");
    build_exp(4'b0000, 1'b0);
    run_step(4'b0000, 1'b0, "t3 release");

    // Three requests during a 0xAA frame merge into one more 0xAA
    @(negedge clk); #1;
    clear_mon();
    start_req = 1'b1;
    @(negedge clk); #1; start_req = 1'b0;
    wait_start(1, 30, "t3b");
    for (int p = 0; p < 3; p++) begin
      repeat (15) @(negedge clk);
      #1; start_req = 1'b1;
      @(negedge clk); #1; start_req = 1'b0;
    end
    repeat (2 * (FRAME + 1) + 60) @(negedge clk); #1;
    exp_q = '{8'hAA, 8'hAA};
    compare_frames("t3b merged starts");

    // Short p2_up pulse inside a frame is never sent
    @(negedge clk); #1;
    clear_mon();
    p1_up = 1'b1;
    wait_start(1, 30, "t4");
    repeat (20) @(negedge clk);
    #1; p2_up = 1'b1;
    repeat (5) @(negedge clk);
    #1; p2_up = 1'b0;
    repeat (FRAME + 60) @(negedge clk); #1;
    exp_q = '{8'h57};
    compare_frames("t4 glitch");
    model_sent = 4'b0001;

    // Reset in the middle of data bit 3 with p1_up held
    build_exp(4'b0000, 1'b0);
    run_step(4'b0000, 1'b0, "t5 prep");
    @(negedge clk); #1;
    clear_mon();
    p1_up = 1'b1;
    wait_start(1, 30, "t5");
    k = 0;
    while (mon_phase != 4 * CPB + CPB/2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("t5 reached bit3", mon_phase, 4 * CPB + CPB/2);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("t5 async uart_tx", uart_tx, 1);
    check("t5 async busy", busy, 0);
    repeat (2) @(negedge clk);
    #1;
    clear_mon();
    rst = 1'b1;
    repeat (FRAME + 40) @(negedge clk); #1;
    exp_q = '{8'h57};
    compare_frames("t5 resend");
    model_sent = 4'b0001;
    build_exp(4'b0000, 1'b0);
    run_step(4'b0000, 1'b0, "t5 release");

    // Encoding table
    for (int i = 0; i < 8; i++) begin
      exp_q.delete();
      for (int j = 0; j < int'(vecs[i].n); j++) exp_q.push_back(vecs[i].b[j]);
      run_step(vecs[i].lv, vecs[i].st, $sformatf("vec%0d", i));
    end

    // Randomized level sets checked against the change-list model
    for (int r = 0; r < 16; r++) begin
      logic [3:0] lv;
      logic       st;
      lv = 4'($urandom_range(0, 15));
      st = ($urandom_range(0, 3) == 0);
      build_exp(lv, st);
      run_step(lv, st, $sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
